// File: rtl/pc_flow_ctrl.sv
// PC / fetch-control stage for the 16-bit WISC single-cycle core.
// Owns the program counter, the N/Z/V flag register and the halt latch; resolves B/BR/HLT.
module pc_flow_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HLT_OPC  = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic [15:0] rs_data,
  input  logic [2:0]  alu_nzv,
  input  logic        stall,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic [2:0]  flags,
  output logic        branch_taken,
  output logic        hlt
);

  localparam logic [3:0] OPC_ADD = 4'h0;
  localparam logic [3:0] OPC_SUB = 4'h1;
  localparam logic [3:0] OPC_XOR = 4'h2;
  localparam logic [3:0] OPC_SLL = 4'h4;
  localparam logic [3:0] OPC_SRA = 4'h5;
  localparam logic [3:0] OPC_ROR = 4'h6;
  localparam logic [3:0] OPC_B   = 4'hC;
  localparam logic [3:0] OPC_BR  = 4'hD;

  logic [15:0] pc_r;
  logic [2:0]  flags_r;
  logic        halted_r;

  logic [15:0] nextPc_s;
  logic [2:0]  nextFlags_s;
  logic        nextHalted_s;
  logic [3:0]  opc_s;
  logic        condTrue_s;
  logic        isHlt_s;
  logic        isBranch_s;
  logic [15:0] branchOffs_s;

  // Branch condition against the registered {N,Z,V}; ALU results are never forwarded.
  function automatic logic evalCond(input logic [2:0] ccc, input logic [2:0] nzv);
    logic n, z, v;
    n = nzv[2];
    z = nzv[1];
    v = nzv[0];
    case (ccc)
      3'b000:  evalCond = ~z;
      3'b001:  evalCond = z;
      3'b010:  evalCond = ~z & ~n;
      3'b011:  evalCond = n;
      3'b100:  evalCond = z | (~z & ~n);
      3'b101:  evalCond = n | z;
      3'b110:  evalCond = v;
      3'b111:  evalCond = 1'b1;
      default: evalCond = 1'b0;
    endcase
  endfunction

  assign opc_s        = instr[15:12];
  assign condTrue_s   = evalCond(instr[11:9], flags_r);
  assign isHlt_s      = (opc_s == HLT_OPC);
  assign isBranch_s   = (opc_s == OPC_B) || (opc_s == OPC_BR);
  assign branchOffs_s = {{6{instr[8]}}, instr[8:0], 1'b0};

  assign pc           = pc_r;
  assign flags        = flags_r;
  assign pc_plus2     = pc_r + 16'd2;
  assign branch_taken = rst_n & isBranch_s & condTrue_s & ~halted_r;
  assign hlt          = halted_r | (rst_n & isHlt_s);

  // Next PC, flag and halt-latch selection.
  always_comb begin
    nextPc_s     = pc_plus2;
    nextFlags_s  = flags_r;
    nextHalted_s = halted_r;
    if (halted_r || isHlt_s) begin
      nextPc_s     = pc_r;
      nextHalted_s = halted_r | ~stall;
    end else if (stall) begin
      nextPc_s = pc_r;
    end else if ((opc_s == OPC_B) && condTrue_s) begin
      nextPc_s = pc_plus2 + branchOffs_s;
    end else if ((opc_s == OPC_BR) && condTrue_s) begin
      nextPc_s = rs_data;
    end else begin
      nextPc_s = pc_plus2;
    end

    // Shift/logic ops update Z only; N and V keep their previous values.
    if (!stall && !halted_r) begin
      case (opc_s)
        OPC_ADD, OPC_SUB: nextFlags_s = alu_nzv;
        OPC_XOR, OPC_SLL, OPC_SRA, OPC_ROR:
          nextFlags_s = {flags_r[2], alu_nzv[1], flags_r[0]};
        default: nextFlags_s = flags_r;
      endcase
    end else begin
      nextFlags_s = flags_r;
    end
  end

  // Architectural state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r     <= RESET_PC;
      flags_r  <= 3'b000;
      halted_r <= 1'b0;
    end else begin
      pc_r     <= nextPc_s;
      flags_r  <= nextFlags_s;
      halted_r <= nextHalted_s;
    end
  end

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Directed self-checking bench for pc_flow_ctrl: reset, flags, branches, halt, stall and wrap.
module tb_pc_flow_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] instr;
  logic [15:0] rs_data;
  logic [2:0]  alu_nzv;
  logic        stall;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic [2:0]  flags;
  logic        branch_taken;
  logic        hlt;

  int errors = 0;
  int checks = 0;

  pc_flow_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .rs_data(rs_data),
    .alu_nzv(alu_nzv), .stall(stall), .pc(pc), .pc_plus2(pc_plus2),
    .flags(flags), .branch_taken(branch_taken), .hlt(hlt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr = 16'h1123; rs_data = 16'h0000; alu_nzv = 3'b111; stall = 1'b0;
    tick(); tick();
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h exp 0000", pc); end
    checks++; if (flags !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", flags); end
    checks++; if (hlt !== 1'b0) begin errors++; $display("FAIL reset_hlt got %b exp 0", hlt); end
    instr = 16'hCE00;
    #1;
    checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL reset_bt got %b exp 0", branch_taken); end
    instr = 16'h8000;
    rst_n = 1'b1;
    #1;
    checks++; if (pc_plus2 !== 16'h0002) begin errors++; $display("FAIL reset_pcp2 got %h exp 0002", pc_plus2); end
    tick();
    checks++; if (pc !== 16'h0002) begin errors++; $display("FAIL step_pc1 got %h exp 0002", pc); end
    tick();
    checks++; if (pc !== 16'h0004) begin errors++; $display("FAIL step_pc2 got %h exp 0004", pc); end
  endtask

  task automatic test_flags_branch();
    instr = 16'h0123; alu_nzv = 3'b010;
    tick();
    checks++; if (flags !== 3'b010) begin errors++; $display("FAIL add_flags got %b exp 010", flags); end
    checks++; if (pc !== 16'h0006) begin errors++; $display("FAIL add_pc got %h exp 0006", pc); end
    instr = 16'hC203; alu_nzv = 3'b000;
    #1;
    checks++; if (branch_taken !== 1'b1) begin errors++; $display("FAIL beq_bt got %b exp 1", branch_taken); end
    tick();
    checks++; if (pc !== 16'h000E) begin errors++; $display("FAIL beq_pc got %h exp 000e", pc); end
    instr = 16'hC003;
    #1;
    checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL bne_bt got %b exp 0", branch_taken); end
    tick();
    checks++; if (pc !== 16'h0010) begin errors++; $display("FAIL bne_pc got %h exp 0010", pc); end
    instr = 16'hCFFE;
    tick();
    checks++; if (pc !== 16'h000E) begin errors++; $display("FAIL bneg_pc got %h exp 000e", pc); end
  endtask

  task automatic test_partial_flags();
    instr = 16'h1000; alu_nzv = 3'b101;
    tick();
    checks++; if (flags !== 3'b101) begin errors++; $display("FAIL sub_flags got %b exp 101", flags); end
    instr = 16'h2000; alu_nzv = 3'b010;
    tick();
    checks++; if (flags !== 3'b111) begin errors++; $display("FAIL xor_flags got %b exp 111", flags); end
    instr = 16'h4000; alu_nzv = 3'b101;
    tick();
    checks++; if (flags !== 3'b101) begin errors++; $display("FAIL sll_flags got %b exp 101", flags); end
    instr = 16'h8000; alu_nzv = 3'b010;
    tick();
    checks++; if (flags !== 3'b101) begin errors++; $display("FAIL nowrite_flags got %b exp 101", flags); end
    // flags = N=1 Z=0 V=1: GT 0, LT 1, GE 0, LE 1, OV 1, EQ 0
    instr = 16'hC400; #1;
    checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL cond_gt got %b exp 0", branch_taken); end
    instr = 16'hC600; #1;
    checks++; if (branch_taken !== 1'b1) begin errors++; $display("FAIL cond_lt got %b exp 1", branch_taken); end
    instr = 16'hC800; #1;
    checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL cond_ge got %b exp 0", branch_taken); end
    instr = 16'hCA00; #1;
    checks++; if (branch_taken !== 1'b1) begin errors++; $display("FAIL cond_le got %b exp 1", branch_taken); end
    instr = 16'hCC00; #1;
    checks++; if (branch_taken !== 1'b1) begin errors++; $display("FAIL cond_ov got %b exp 1", branch_taken); end
    instr = 16'hD200; #1;
    checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL cond_breq got %b exp 0", branch_taken); end
  endtask

  task automatic test_br();
    instr = 16'hDE50; rs_data = 16'h1234;
    #1;
    checks++; if (branch_taken !== 1'b1) begin errors++; $display("FAIL br_bt got %b exp 1", branch_taken); end
    tick();
    checks++; if (pc !== 16'h1234) begin errors++; $display("FAIL br_pc got %h exp 1234", pc); end
    rs_data = 16'h0020;
    tick();
    checks++; if (pc !== 16'h0020) begin errors++; $display("FAIL br20_pc got %h exp 0020", pc); end
  endtask

  task automatic test_halt();
    instr = 16'hF000;
    #1;
    checks++; if (hlt !== 1'b1) begin errors++; $display("FAIL hlt_comb got %b exp 1", hlt); end
    tick();
    instr = 16'h0000; alu_nzv = 3'b010;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) instr = 16'hCE04;
      if (i == 2) instr = 16'hDE00;
      tick();
      checks++; if (pc !== 16'h0020) begin errors++; $display("FAIL hlt_pc%0d got %h exp 0020", i, pc); end
      checks++; if (flags !== 3'b101) begin errors++; $display("FAIL hlt_flags%0d got %b exp 101", i, flags); end
      checks++; if (hlt !== 1'b1) begin errors++; $display("FAIL hlt_hold%0d got %b exp 1", i, hlt); end
      checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL hlt_bt%0d got %b exp 0", i, branch_taken); end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (hlt !== 1'b0) begin errors++; $display("FAIL hlt_rst got %b exp 0", hlt); end
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL hlt_rst_pc got %h exp 0000", pc); end
    checks++; if (flags !== 3'b000) begin errors++; $display("FAIL hlt_rst_flags got %b exp 000", flags); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_stall_wrap();
    instr = 16'hC200; alu_nzv = 3'b010;
    #1;
    checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL no_fwd got %b exp 0", branch_taken); end
    instr = 16'hDE00; rs_data = 16'h0030;
    tick();
    checks++; if (pc !== 16'h0030) begin errors++; $display("FAIL br30_pc got %h exp 0030", pc); end
    instr = 16'h0000; alu_nzv = 3'b111; stall = 1'b1;
    tick(); tick();
    checks++; if (pc !== 16'h0030) begin errors++; $display("FAIL stall_pc got %h exp 0030", pc); end
    checks++; if (flags !== 3'b000) begin errors++; $display("FAIL stall_flags got %b exp 000", flags); end
    instr = 16'hF000;
    #1;
    checks++; if (hlt !== 1'b1) begin errors++; $display("FAIL stall_hlt got %b exp 1", hlt); end
    tick();
    checks++; if (pc !== 16'h0030) begin errors++; $display("FAIL stall_hlt_pc got %h exp 0030", pc); end
    stall = 1'b0; instr = 16'h8000;
    #1;
    checks++; if (hlt !== 1'b0) begin errors++; $display("FAIL stall_nolatch got %b exp 0", hlt); end
    tick();
    checks++; if (pc !== 16'h0032) begin errors++; $display("FAIL unstall_pc got %h exp 0032", pc); end
    instr = 16'hDE00; rs_data = 16'hFFFE;
    tick();
    checks++; if (pc_plus2 !== 16'h0000) begin errors++; $display("FAIL wrap_pcp2 got %h exp 0000", pc_plus2); end
    instr = 16'h8000;
    tick();
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc got %h exp 0000", pc); end
  endtask

  initial begin
    test_reset();
    test_flags_branch();
    test_partial_flags();
    test_br();
    test_halt();
    test_stall_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_flow_ctrl.md
Name: pc_flow_ctrl

Overview:
- PC/fetch-control stage directly upstream of the single-cycle cpu datapath.
- Owns the program counter, the N/Z/V flag register and the halt latch.
- Drives `pc` to instruction memory and resolves B/BR/HLT for the 16-bit WISC ISA; exports the `pc`/`hlt` pair seen at the cpu top level.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HLT_OPC, 4'hF, opcode of HLT.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- instr  input  16  instruction currently fetched from imem at `pc`
- rs_data  input  16  register-file read of instr[7:4], the target for BR
- alu_nzv  input  3  {N,Z,V} produced by the ALU for the current instr
- stall  input  1  hold PC and flags this cycle (phase-2 hook); tie 0 in single-cycle
- pc  output  16  current PC to imem
- pc_plus2  output  16  pc+2, used for PCS write-back
- flags  output  3  registered {N,Z,V}
- branch_taken  output  1  current instr redirects next PC
- hlt  output  1  halt executed/halted

Behaviour:
- One clock; reset is asynchronous and active-low. rst_n=0 immediately forces pc=RESET_PC, flags=3'b000, halted latch=0.
- While rst_n=0, hlt=0 and branch_taken=0 regardless of instr.
- Decode uses opc=instr[15:12].
- Flag update (registered, end of the instr's cycle), only when not stalled and not halted:
  - ADD 0000, SUB 0001: write N,Z,V.
  - XOR 0010, SLL 0100, SRA 0101, ROR 0110: write Z only; N,V hold.
  - All other opcodes: no flag write.
- Condition ccc=instr[11:9], evaluated against the registered flags (not alu_nzv):
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 & N=0
  - 011 LT: N=1
  - 100 GE: Z=1 | (Z=0 & N=0)
  - 101 LE: N=1 | Z=1
  - 110 OV: V=1
  - 111: always
- Next PC, priority order:
  1. halted or HLT: pc holds.
  2. stall: pc holds.
  3. B 1100 with condition true: pc_plus2 + (sign-extended instr[8:0] << 1). Arithmetic is 16-bit with wrap-around and no overflow detect.
  4. BR 1101 with condition true: rs_data.
  5. Otherwise: pc_plus2.
- `branch_taken` is combinational: (opc==1100|1101) & condition true & ~halted.
- `pc_plus2` is combinational pc+16'd2; it wraps 16'hFFFE→16'h0000.
- Halt:
  - hlt = halted | (rst_n & opc==HLT_OPC).
  - The latch sets at the posedge where opc==HLT and stall=0, and stays set until reset.
  - Once halted, pc, flags and halted are frozen and instr is ignored.
- HLT under stall: hlt still asserts combinationally, but the latch does not set and pc holds.
- Flags written by an instr are visible to a branch the next cycle. Same-cycle ALU results are not forwarded.
- Reset mid-operation aborts any pending branch; the next fetch is at RESET_PC.
- Latency: 1 cycle from an instr being presented to `pc` reflecting its successor.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with instr=16'h1123 → pc=0000, flags=000, hlt=0. Release → pc steps 0000, 0002, 0004.
- Flags + branch:
  - ADD with alu_nzv=3'b010 at pc=0004 → flags=010.
  - Next instr B EQ imm=+3 (16'hC203) at pc=0006 → branch_taken=1, next pc=000E.
  - Same branch as NE (16'hC003) → pc=0008.
- Partial flags: flags=3'b101, then XOR with alu_nzv=3'b010 → flags=111.
- BR and negative offset:
  - BR always (16'hDE50) with rs_data=1234 → next pc=1234.
  - B always, imm=9'h1FE at pc=0010 → next pc=000E.
- Halt: HLT (16'hF000) at pc=0020 → hlt=1 that cycle; pc stays 0020 for ≥3 cycles with arbitrary instr; flags unchanged. Assert rst_n=0 → hlt=0, pc=0000 asynchronously.
- Stall/wrap:
  - stall=1 for 2 cycles at pc=0030 with an ADD → pc and flags unchanged.
  - pc=FFFE, non-branch → next pc=0000.
